// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Shares one UART transmitter between NUM_REQ byte-stream sources.
//            The arbiter is round-robin. A grant lasts for a burst of up to
//            MAX_BURST bytes. When TAG_EN is set, a channel-tag byte
//            (TAG_BASE + index) is sent ahead of each burst.
// Ports    : clk            system clock
//            rst_n          asynchronous reset, active-low
//            en             block enable; low clears all state synchronously
//            s_axis_tdata   source bytes, channel i at [8*i+7:8*i]
//            s_axis_tvalid  source byte valid, one bit per channel
//            s_axis_tready  source byte accepted, one bit per channel
//            m_axis_tdata   byte to uart_tx
//            m_axis_tvalid  byte valid to uart_tx
//            m_axis_tready  uart_tx accepts byte
//            grant_id       index of the granted source
//            grant_valid    a grant is active (TAG or DATA state)
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int         NUM_REQ   = 4,
  parameter int         ID_W      = 2,
  parameter int         MAX_BURST = 16,
  parameter bit         TAG_EN    = 1'b1,
  parameter logic [7:0] TAG_BASE  = 8'hA0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [8*NUM_REQ-1:0] s_axis_tdata,
  input  logic [NUM_REQ-1:0]   s_axis_tvalid,
  output logic [NUM_REQ-1:0]   s_axis_tready,
  output logic [7:0]           m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [ID_W-1:0]      grant_id,
  output logic                 grant_valid
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TAG  = 2'd1,
    S_DATA = 2'd2
  } state_t;

  localparam logic [7:0]      c_MAX_BURST = 8'(MAX_BURST);
  localparam logic [ID_W-1:0] c_LAST_ID   = ID_W'(NUM_REQ - 1);

  state_t          r_state;
  logic [ID_W-1:0] r_rr_ptr;
  logic [7:0]      r_cnt;

  logic            w_free;
  logic            w_src_valid;
  logic [7:0]      w_src_data;
  logic            w_found;
  logic [ID_W-1:0] w_pick;
  logic            w_xfer;
  logic            w_exit;

  // The output register can take a new byte when it is empty or is being
  // drained in this same cycle.
  assign w_free = !m_axis_tvalid || m_axis_tready;

  // Select the granted source's valid and data.
  always_comb begin
    w_src_valid = 1'b0;
    w_src_data  = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        w_src_valid = s_axis_tvalid[i];
        w_src_data  = s_axis_tdata[8*i +: 8];
      end
    end
  end

  // Round-robin pick in two passes. The first pass looks for the lowest
  // requester at or above r_rr_ptr. If none is found, the second pass takes
  // the lowest requester overall. That requester is below r_rr_ptr, so the
  // two passes together cover the wrap-around.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && s_axis_tvalid[i] && (ID_W'(i) >= r_rr_ptr)) begin
        w_found = 1'b1;
        w_pick  = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && s_axis_tvalid[i]) begin
        w_found = 1'b1;
        w_pick  = ID_W'(i);
      end
    end
  end

  always_comb begin
    s_axis_tready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      s_axis_tready[i] = en && (r_state == S_DATA) && (grant_id == ID_W'(i)) && w_free;
    end
  end

  assign w_xfer = (r_state == S_DATA) && w_free && w_src_valid;
  // A burst ends when the byte that reaches the limit is transferred, or when
  // the output register is free and the source has nothing to offer.
  assign w_exit = (r_state == S_DATA) &&
                  ((w_xfer && ((r_cnt + 8'd1) == c_MAX_BURST)) ||
                   (w_free && !w_src_valid));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_rr_ptr      <= '0;
      r_cnt         <= 8'd0;
      m_axis_tdata  <= 8'h00;
      m_axis_tvalid <= 1'b0;
      grant_id      <= '0;
      grant_valid   <= 1'b0;
    end else if (!en) begin
      r_state       <= S_IDLE;
      r_rr_ptr      <= '0;
      r_cnt         <= 8'd0;
      m_axis_tdata  <= 8'h00;
      m_axis_tvalid <= 1'b0;
      grant_id      <= '0;
      grant_valid   <= 1'b0;
    end else begin
      // Drain the output register. A load below in the same cycle overrides
      // this clear.
      if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            grant_id    <= w_pick;
            grant_valid <= 1'b1;
            r_cnt       <= 8'd0;
            r_state     <= TAG_EN ? S_TAG : S_DATA;
          end
        end
        S_TAG: begin
          if (w_free) begin
            m_axis_tdata  <= TAG_BASE + 8'(grant_id);
            m_axis_tvalid <= 1'b1;
            r_state       <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_xfer) begin
            m_axis_tdata  <= w_src_data;
            m_axis_tvalid <= 1'b1;
            r_cnt         <= r_cnt + 8'd1;
          end
          if (w_exit) begin
            r_state     <= S_IDLE;
            grant_valid <= 1'b0;
            r_rr_ptr    <= (grant_id == c_LAST_ID) ? '0 : grant_id + ID_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
